// File: rtl/parallel_out_pkg.sv
// Shared types for the parallel output bank: per-address access mode encoding.
package parallel_out_pkg;

    localparam int MODE_BITS = 2;

    typedef enum logic [MODE_BITS-1:0] {
        WM_WRITE = 2'b00,
        WM_SET   = 2'b01,
        WM_CLR   = 2'b10,
        WM_TGL   = 2'b11
    } wr_mode_t;

endpackage

// File: rtl/parallel_out_bank_if.sv
// CPU data bus view of the output bank: address/data/write plus decode feedback.
interface parallel_out_bank_if #(
    parameter int AW = 8,
    parameter int W  = 8
);
    logic          we;
    logic [AW-1:0] address;
    logic [W-1:0]  regData;
    logic [W-1:0]  rdData;
    logic          hit;
    logic          wren;

    modport master (
        output we, address, regData,
        input  rdData, hit, wren
    );

    modport slave (
        input  we, address, regData,
        output rdData, hit, wren
    );
endinterface

// File: rtl/parallel_out_chan.sv
// One output channel: value register with set/clear/toggle access, optional
// auto-clearing pulse timer, and a change strobe aligned with the new value.
module parallel_out_chan
    import parallel_out_pkg::*;
#(
    parameter int W         = 8,
    parameter int PULSE_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  wr_mode_t     mode,
    input  logic [W-1:0] wdata,
    input  logic         pulse_en,
    output logic [W-1:0] value,
    output logic         upd
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [W-1:0]  val_r;
    logic [W-1:0]  val_next_s;
    logic [W-1:0]  result_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          upd_r;

    // Access-mode arithmetic on the current value.
    always_comb begin
        result_s = val_r;
        case (mode)
            WM_WRITE: result_s = wdata;
            WM_SET:   result_s = val_r | wdata;
            WM_CLR:   result_s = val_r & ~wdata;
            WM_TGL:   result_s = val_r ^ wdata;
            default:  result_s = val_r;
        endcase
    end

    // Next value and pulse counter; a write outranks expiry on the same edge.
    always_comb begin
        val_next_s = val_r;
        cnt_next_s = cnt_r;
        if (wr) begin
            val_next_s = result_s;
            if (pulse_en && (result_s != {W{1'b0}})) begin
                cnt_next_s = CW'(PULSE_LEN);
            end else begin
                cnt_next_s = {CW{1'b0}};
            end
        end else if (!pulse_en) begin
            cnt_next_s = {CW{1'b0}};
        end else if (cnt_r == CW'(1)) begin
            val_next_s = {W{1'b0}};
            cnt_next_s = {CW{1'b0}};
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_next_s = cnt_r - CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Channel state and change strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_r <= {W{1'b0}};
            cnt_r <= {CW{1'b0}};
            upd_r <= 1'b0;
        end else begin
            val_r <= val_next_s;
            cnt_r <= cnt_next_s;
            upd_r <= (val_next_s != val_r);
        end
    end

    assign value = val_r;
    assign upd   = upd_r;

endmodule

// File: rtl/parallel_out_bank.sv
// Memory-mapped bank of N output channels plus a pulse-enable CTRL register,
// decoded from a 4*N+1 address window starting at BASE_ADDR.
module parallel_out_bank
    import parallel_out_pkg::*;
#(
    parameter int          W         = 8,
    parameter int          N         = 4,
    parameter int          AW        = 8,
    parameter int unsigned BASE_ADDR = 8'hE0,
    parameter int          PULSE_LEN = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    parallel_out_bank_if.slave  bus,
    output logic [N*W-1:0]      dataOut,
    output logic [N-1:0]        upd
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);
    localparam logic [AW-1:0] CTRL_OFF = AW'(4 * N);

    if ((BASE_ADDR % 4) != 0) begin : g_bad_base_align
        $error("parallel_out_bank: BASE_ADDR must be a multiple of 4");
    end
    if ((BASE_ADDR + 4 * N) >= (2 ** AW)) begin : g_bad_window
        $error("parallel_out_bank: address window exceeds the address space");
    end
    if ((N < 1) || (N > 16) || (PULSE_LEN < 1)) begin : g_bad_params
        $error("parallel_out_bank: N must be 1..16 and PULSE_LEN >= 1");
    end

    logic [AW-1:0] off_s;
    logic          chan_hit_s;
    logic          ctrl_hit_s;
    logic [IW-1:0] chan_idx_s;
    wr_mode_t      mode_s;
    logic [N-1:0]  ctrl_r;
    logic [N-1:0]  ctrl_next_s;
    logic [N-1:0]  ctrl_wdata_s;
    logic [W-1:0]  ctrl_rd_s;
    logic [W-1:0]  chan_val_s [N];
    logic [W-1:0]  rd_data_s;

    // Window offset wraps for addresses below BASE, so they decode as misses.
    assign off_s      = bus.address - BASE;
    assign chan_hit_s = (off_s < CTRL_OFF);
    assign ctrl_hit_s = (off_s == CTRL_OFF);
    assign chan_idx_s = off_s[2 +: IW];
    assign mode_s     = wr_mode_t'(off_s[MODE_BITS-1:0]);

    assign bus.hit  = chan_hit_s | ctrl_hit_s;
    assign bus.wren = bus.we & (chan_hit_s | ctrl_hit_s);

    for (genvar b = 0; b < N; b++) begin : g_ctrl_wdata
        if (b < W) begin : g_bit
            assign ctrl_wdata_s[b] = bus.regData[b];
        end else begin : g_zero
            assign ctrl_wdata_s[b] = 1'b0;
        end
    end

    for (genvar b = 0; b < W; b++) begin : g_ctrl_rd
        if (b < N) begin : g_bit
            assign ctrl_rd_s[b] = ctrl_r[b];
        end else begin : g_zero
            assign ctrl_rd_s[b] = 1'b0;
        end
    end

    // Next CTRL value; channels see it so a clearing write stops a pulse at once.
    always_comb begin
        ctrl_next_s = ctrl_r;
        if (bus.wren && ctrl_hit_s) begin
            ctrl_next_s = ctrl_wdata_s;
        end else begin
            ctrl_next_s = ctrl_r;
        end
    end

    // CTRL register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= {N{1'b0}};
        end else begin
            ctrl_r <= ctrl_next_s;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic chan_wr_s;
        assign chan_wr_s = bus.wren && chan_hit_s && (chan_idx_s == IW'(i));

        parallel_out_chan #(
            .W         (W),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (chan_wr_s),
            .mode     (mode_s),
            .wdata    (bus.regData),
            .pulse_en (ctrl_next_s[i]),
            .value    (chan_val_s[i]),
            .upd      (upd[i])
        );

        assign dataOut[i*W +: W] = chan_val_s[i];
    end

    // Readback mux: any of a channel's four mode addresses returns its value.
    always_comb begin
        rd_data_s = {W{1'b0}};
        if (chan_hit_s) begin
            rd_data_s = chan_val_s[chan_idx_s];
        end else if (ctrl_hit_s) begin
            rd_data_s = ctrl_rd_s;
        end else begin
            rd_data_s = {W{1'b0}};
        end
    end

    assign bus.rdData = rd_data_s;

endmodule

// File: tb/tb_parallel_out_bank.sv
// Randomised scoreboard bench for parallel_out_bank against an absolute-time
// reference model (each pulse is tracked by the cycle at which it expires).
module tb_parallel_out_bank;

    localparam int W         = 8;
    localparam int N         = 4;
    localparam int AW        = 8;
    localparam int BASE      = 8'hE0;
    localparam int PULSE_LEN = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*W-1:0] dataOut;
    logic [N-1:0]   upd;

    parallel_out_bank_if #(.AW(AW), .W(W)) bus ();

    parallel_out_bank #(
        .W(W), .N(N), .AW(AW), .BASE_ADDR(BASE), .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dataOut (dataOut),
        .upd     (upd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W+1:0]       comb_q  [$];
    logic [N*W+N-1:0]   state_q [$];

    logic [W-1:0] m_val [N];
    logic [N-1:0] m_ctrl;
    int           m_exp [N];
    int           cyc;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_val[c] = '0;
            m_exp[c] = -1;
        end
        m_ctrl = '0;
    endtask

    // One bus cycle: drive at the falling edge, queue expected responses.
    task automatic step(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [7:0]   off;
        logic         hc, hk;
        logic [W-1:0] rd, nv;
        logic [N-1:0] ctrl_n, eu;
        logic [N*W-1:0] ed;
        @(negedge clk);
        bus.we = w; bus.address = a; bus.regData = d;
        off = a - 8'(BASE);
        hc  = (off < 8'(4 * N));
        hk  = (off == 8'(4 * N));
        rd  = hc ? m_val[off[3:2]] : (hk ? W'(m_ctrl) : 8'h00);
        comb_q.push_back({hc | hk, w & (hc | hk), rd});
        ctrl_n = m_ctrl;
        if (w && hk) ctrl_n = d[N-1:0];
        for (int c = 0; c < N; c++) begin
            if (!ctrl_n[c]) m_exp[c] = -1;
            nv = m_val[c];
            if (w && hc && (int'(off[3:2]) == c)) begin
                case (off[1:0])
                    2'd0: nv = d;
                    2'd1: nv = m_val[c] | d;
                    2'd2: nv = m_val[c] & ~d;
                    default: nv = m_val[c] ^ d;
                endcase
                m_exp[c] = (ctrl_n[c] && nv != 0) ? cyc + PULSE_LEN : -1;
            end else if (m_exp[c] == cyc) begin
                nv = '0;
                m_exp[c] = -1;
            end
            eu[c] = (nv != m_val[c]);
            m_val[c] = nv;
            ed[c*W +: W] = nv;
        end
        m_ctrl = ctrl_n;
        state_q.push_back({ed, eu});
        cyc++;
    endtask

    task automatic idle(input int n, input logic [7:0] a);
        for (int k = 0; k < n; k++) step(1'b0, a, 8'($urandom));
    endtask

    // Combinational decode/readback monitor, sampled mid-low-phase.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk); #2;
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                checks++;
                if ({bus.hit, bus.wren, bus.rdData} !== e) begin
                    errors++;
                    $display("FAIL comb addr=%h hit/wren/rd got %b/%b/%h want %b/%b/%h",
                             bus.address, bus.hit, bus.wren, bus.rdData, e[W+1], e[W], e[W-1:0]);
                end
            end
        end
    end

    // Registered output monitor, sampled just after the active edge.
    initial begin
        logic [N*W+N-1:0] e;
        forever begin
            @(posedge clk); #1;
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                checks++;
                if ({dataOut, upd} !== e) begin
                    errors++;
                    $display("FAIL state cyc=%0d dataOut/upd got %h/%b want %h/%b",
                             cyc, dataOut, upd, e[N*W+N-1:N], e[N-1:0]);
                end
            end
        end
    end

    task automatic direct_check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] a;
        bus.we = 1'b0; bus.address = 8'h00; bus.regData = 8'h00;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        direct_check("reset_dataOut", 32'(dataOut), 32'h0);
        direct_check("reset_upd", 32'(upd), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Channel access modes and readback.
        step(1'b1, 8'hE4, 8'hA5);
        step(1'b1, 8'hE5, 8'h0F);
        step(1'b1, 8'hE6, 8'hA0);
        step(1'b1, 8'hE7, 8'hFF);
        step(1'b1, 8'hE5, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b0, 8'(8'hE4 + k), 8'h00);

        // Pulse, retrigger, then disable mid-pulse.
        step(1'b1, 8'hF0, 8'h04);
        step(1'b1, 8'hE8, 8'h3C);
        idle(20, 8'hF0);
        step(1'b1, 8'hE8, 8'h3C);
        idle(9, 8'hE8);
        step(1'b1, 8'hE8, 8'h11);
        idle(20, 8'hE9);
        step(1'b1, 8'hE8, 8'h11);
        idle(5, 8'hE8);
        step(1'b1, 8'hF0, 8'h00);
        idle(20, 8'hE8);

        // Out-of-window accesses.
        step(1'b1, 8'hDF, 8'hFF);
        step(1'b1, 8'hF1, 8'hFF);
        step(1'b1, 8'h00, 8'h5A);
        idle(2, 8'hF1);

        // Asynchronous reset mid-pulse.
        step(1'b1, 8'hF0, 8'h04);
        step(1'b1, 8'hE8, 8'h3C);
        idle(5, 8'hE8);
        @(posedge clk); #3;
        bus.we = 1'b0; bus.address = 8'hF0;
        rst_n = 1'b0;
        #1;
        direct_check("async_rst_dataOut", 32'(dataOut), 32'h0);
        direct_check("async_rst_upd", 32'(upd), 32'h0);
        direct_check("async_rst_ctrl", 32'(bus.rdData), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        idle(20, 8'hE8);

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            if (($urandom % 5) != 0) a = 8'(8'hE0 + ($urandom % 17));
            else a = 8'($urandom);
            if (($urandom % 4) == 0) idle(int'($urandom % 20), a);
            else step(($urandom % 3) != 0, a, 8'($urandom));
        end
        idle(2, 8'hE0);

        repeat (3) @(posedge clk);
        #2;
        direct_check("queues_drained", 32'(comb_q.size() + state_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_out_bank.md
Name: parallel_out_bank

Overview:
- Parametrised memory-mapped parallel output bank for the CPU data bus: N output channels of W bits each, decoded from a contiguous address window at BASE_ADDR.
- Each channel supports direct write, bit-set, bit-clear and bit-toggle access, plus readback.
- A per-channel pulse mode auto-clears the channel after PULSE_LEN cycles.
- A per-channel update strobe tells downstream logic (LED/7-seg drivers, peripherals) when a channel value changed.

Parameters:
- W, 8, channel data width (bits).
- N, 4, number of output channels (1..16).
- AW, 8, address bus width.
- BASE_ADDR, 8'hE0, first address of window; multiple of 4; BASE_ADDR+4*N must be < 2**AW (elaboration-time assertion).
- PULSE_LEN, 16, pulse-mode hold time in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  bus write enable.
- address  in  AW  bus address.
- regData  in  W  bus write data.
- rdData  out  W  combinational readback data.
- hit  out  1  combinational: address is inside the window (channels + CTRL).
- wren  out  1  combinational: we & hit (write acknowledge).
- dataOut  out  N*W  channel registers; channel i at [i*W +: W].
- upd  out  N  registered one-cycle strobe per channel.

Behaviour:
- Address map:
  - off = address - BASE_ADDR.
  - For off < 4*N: channel = off[..:2], mode = off[1:0] (00 WRITE, 01 SET, 10 CLR, 11 TGL).
  - CTRL register (N bits, pulse-enable mask) is at off == 4*N.
  - Anything else: hit=0, wren=0, rdData=0, no state change.
- Reads: rdData = channel register for any of its 4 mode addresses; CTRL zero-extended to W at the CTRL address; 0 otherwise.
- Writes take effect on the rising edge with we&hit; new value visible the following cycle.
  - WRITE: r <= regData.
  - SET: r <= r | regData.
  - CLR: r <= r & ~regData.
  - TGL: r <= r ^ regData.
- Pulse mode (CTRL[i]=1):
  - A channel write whose result is nonzero loads cnt_i = PULSE_LEN.
  - cnt_i decrements on each later edge while nonzero.
  - On the edge where cnt_i==1, r_i <= 0 and cnt_i <= 0.
  - Net effect: the value is held for exactly PULSE_LEN cycles.
  - A write with zero result sets cnt_i=0.
  - A write during an active pulse reloads cnt_i (retrigger).
- Pulse mode off (CTRL[i]=0): cnt_i held at 0, r_i static.
  - Writing CTRL to clear bit i while cnt_i != 0: cnt_i <= 0; r_i keeps its current value.
  - Setting bit i does not start a pulse on its own.
- Simultaneous events: a channel write on the same edge as expiry wins (write result and reload apply, no clear).
- upd[i] <= (r_i_next != r_i).
  - High exactly in the first cycle dataOut shows the new value.
  - Not asserted by writes that leave the value unchanged.
- Reset (asynchronous, immediate on rst_n low): all r_i = 0, CTRL = 0, all cnt_i = 0, upd = 0.
  - Reset mid-pulse aborts the pulse.
  - No upd is generated on reset release.
- Counter width: $clog2(PULSE_LEN+1). All arithmetic is unsigned W-bit, no carries.

Decomposition:
- Package parallel_out_pkg: typedef enum logic [1:0] wr_mode_t {WM_WRITE, WM_SET, WM_CLR, WM_TGL}; localparam MODE_BITS=2.
- Sub-module parallel_out_chan (params W, PULSE_LEN): one channel register, its pulse counter and its upd flop, instantiated N times by generate.
  - Inputs: wr, mode, wdata, pulse_en.
  - Outputs: value, upd.
- The top holds the address decode, CTRL register and readback mux.

Test Plan:
- Reset then write 0xE4<-0xA5 -> dataOut[15:8]=0xA5 next cycle, upd=4'b0010 for one cycle, wren=1 and hit=1 during the write.
- Channel 1, in order: SET 0xE5<-0x0F -> 0xAF; CLR 0xE6<-0xA0 -> 0x0F; TGL 0xE7<-0xFF -> 0xF0; SET 0xE5<-0x00 -> value unchanged, upd stays 0. Readback at 0xE4..0xE7 each returns the current value.
- Write CTRL 0xF0<-0x04, then 0xE8<-0x3C -> ch2=0x3C for exactly 16 cycles then 0x00; upd[2] pulses at set and at clear; rdData@0xF0=0x04.
- Same setup, rewrite 0xE8<-0x11 at cycle 10 -> ch2=0x11 for 16 more cycles. Then clear CTRL mid-pulse -> value 0x11 held indefinitely.
- Writes to 0xDF and 0xF1 -> hit=0, wren=0, rdData=0, no dataOut/upd change.
- Drive rst_n low asynchronously mid-pulse (between clock edges) -> dataOut=0, upd=0, CTRL=0 immediately. After release, the pulse does not resume.
